// File: rtl/capture_fifo_arbiter_if.sv
// capture_fifo_arbiter_if: bus bundle between the capture sources/FIFO and the arbiter.
//   enable   : capture enable (sources -> arbiter)
//   req_s    : per-source one-cycle capture strobe
//   req_dt   : per-source payload, source i at [i*DW +: DW]
//   drop_clr : synchronous clear of all drop counters
//   full     : FIFO full flag
//   push_s   : FIFO push strobe (arbiter -> FIFO)
//   push_dt  : FIFO push word {src_id[1:0], payload}
//   pending  : holding register valid per source
//   drop_cnt : per-source saturating drop counters, source i at [i*CW +: CW]
interface capture_fifo_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 22,
    parameter int CW   = 8
);
    logic                 enable;
    logic [NREQ-1:0]      req_s;
    logic [NREQ*DW-1:0]   req_dt;
    logic                 drop_clr;
    logic                 full;
    logic                 push_s;
    logic [DW+1:0]        push_dt;
    logic [NREQ-1:0]      pending;
    logic [NREQ*CW-1:0]   drop_cnt;

    modport master (
        output enable, req_s, req_dt, drop_clr, full,
        input  push_s, push_dt, pending, drop_cnt
    );

    modport slave (
        input  enable, req_s, req_dt, drop_clr, full,
        output push_s, push_dt, pending, drop_cnt
    );
endinterface

// File: rtl/capture_fifo_arbiter.sv
// capture_fifo_arbiter: round-robin drain of per-source one-entry holding registers into one FIFO push port.
//   clk    : system clock
//   nreset : asynchronous active-low reset
//   bus    : slave side of capture_fifo_arbiter_if (strobes/payloads/full in; push/pending/drop counts out)
module capture_fifo_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 22,
    parameter int CW   = 8
) (
    input logic                   clk,
    input logic                   nreset,
    capture_fifo_arbiter_if.slave bus
);
    logic [NREQ-1:0] hold_v_q, hold_v_d;
    logic [DW-1:0]   hold_dt_q [NREQ];
    logic [DW-1:0]   hold_dt_d [NREQ];
    logic [CW-1:0]   drop_cnt_q [NREQ];
    logic [CW-1:0]   drop_cnt_d [NREQ];
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic            push_s_q, push_s_d;
    logic [DW+1:0]   push_dt_q, push_dt_d;
    logic            grant;
    logic [1:0]      winner;
    logic [1:0]      idx;

    // Scan from farthest to nearest so the valid source closest to rr_ptr is assigned last and wins.
    always_comb begin
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = 2'((int'(rr_ptr_q) + k) % NREQ);
            if (hold_v_q[idx]) winner = idx;
        end
        grant = !bus.full && |hold_v_q;
    end

    always_comb begin
        hold_v_d   = hold_v_q;
        hold_dt_d  = hold_dt_q;
        drop_cnt_d = drop_cnt_q;
        push_s_d   = grant;
        push_dt_d  = grant ? {winner, hold_dt_q[winner]} : push_dt_q;
        rr_ptr_d   = !grant ? rr_ptr_q : (int'(winner) == NREQ - 1) ? 2'd0 : winner + 2'd1;
        for (int i = 0; i < NREQ; i++) begin
            if (grant && winner == 2'(i)) hold_v_d[i] = 1'b0;
            // A slot freed by this edge's grant can take the new strobe without loss.
            if (bus.enable && bus.req_s[i]) begin
                if (!hold_v_d[i]) begin
                    hold_v_d[i]  = 1'b1;
                    hold_dt_d[i] = bus.req_dt[i*DW +: DW];
                end else if (drop_cnt_q[i] != '1) begin
                    drop_cnt_d[i] = drop_cnt_q[i] + CW'(1);
                end
            end
            if (bus.drop_clr) drop_cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold_v_q   <= '0;
            push_s_q   <= 1'b0;
            push_dt_q  <= '0;
            rr_ptr_q   <= 2'd0;
            drop_cnt_q <= '{default: '0};
        end else begin
            hold_v_q   <= hold_v_d;
            push_s_q   <= push_s_d;
            push_dt_q  <= push_dt_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Holding data is qualified by hold_v, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_dt_q <= hold_dt_d;
    end

    assign bus.push_s  = push_s_q;
    assign bus.push_dt = push_dt_q;
    assign bus.pending = hold_v_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_drop
        assign bus.drop_cnt[g*CW +: CW] = drop_cnt_q[g];
    end
endmodule

// File: tb/tb_capture_fifo_arbiter.sv
// tb_capture_fifo_arbiter: scoreboard bench for capture_fifo_arbiter with directed and random stimulus.
//   Drives the master side of capture_fifo_arbiter_if; a transaction-level model predicts pushes,
//   pending and drop counts; a monitor compares them one step after each rising edge.
module tb_capture_fifo_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 22;
    localparam int CW   = 8;

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    capture_fifo_arbiter_if #(.NREQ(NREQ), .DW(DW), .CW(CW)) bus ();

    capture_fifo_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW+1:0]      exp_q[$];
    logic               m_v [NREQ];
    logic [DW-1:0]      m_dt [NREQ];
    int                 m_drop [NREQ];
    int                 m_rr;
    logic               exp_push;
    logic [DW+1:0]      exp_last;
    logic [NREQ-1:0]    exp_pend;
    logic [NREQ*CW-1:0] exp_drop;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void publish();
        for (int i = 0; i < NREQ; i++) begin
            exp_pend[i]            = m_v[i];
            exp_drop[i*CW +: CW]   = CW'(m_drop[i]);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_rr     = 0;
        exp_push = 1'b0;
        exp_last = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_v[i]    = 1'b0;
            m_drop[i] = 0;
        end
        publish();
    endfunction

    function automatic logic [NREQ*DW-1:0] pk(logic [DW-1:0] d0, logic [DW-1:0] d1, logic [DW-1:0] d2);
        return {d2, d1, d0};
    endfunction

    // Drive one cycle of inputs and predict the effect of the next rising edge:
    // the round-robin winner leaves first, then strobes land in free slots or count as drops.
    task automatic cycle(logic en, logic [NREQ-1:0] req, logic [NREQ*DW-1:0] dt, logic clr, logic fl);
        int g = -1;
        bus.enable   = en;
        bus.req_s    = req;
        bus.req_dt   = dt;
        bus.drop_clr = clr;
        bus.full     = fl;
        if (nreset) begin
            if (!fl) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_v[(m_rr + k) % NREQ]) begin
                        g = (m_rr + k) % NREQ;
                        break;
                    end
                end
            end
            exp_push = (g >= 0);
            if (g >= 0) begin
                exp_last = {2'(g), m_dt[g]};
                exp_q.push_back(exp_last);
                m_v[g] = 1'b0;
                m_rr   = (g + 1) % NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (en && req[i]) begin
                    if (!m_v[i]) begin
                        m_v[i]  = 1'b1;
                        m_dt[i] = dt[i*DW +: DW];
                    end else if (m_drop[i] < (1 << CW) - 1) begin
                        m_drop[i]++;
                    end
                end
                if (clr) m_drop[i] = 0;
            end
            publish();
        end
        @(negedge clk);
    endtask

    task automatic idle(int n, logic fl = 1'b0);
        for (int i = 0; i < n; i++) cycle(1'b1, '0, '0, 1'b0, fl);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        model_reset();
        idle(2);
        nreset = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        chk("push_s", bus.push_s, exp_push);
        if (bus.push_s) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL push_dt: got unexpected push %0h, none expected at %0t", bus.push_dt, $time);
            end else begin
                chk("push_dt", bus.push_dt, exp_q.pop_front());
            end
        end else begin
            chk("push_dt_hold", bus.push_dt, exp_last);
        end
        chk("pending", bus.pending, exp_pend);
        chk("drop_cnt", bus.drop_cnt, exp_drop);
    end

    initial begin
        logic [95:0] r;
        model_reset();
        do_reset();

        // single strobe on source 1
        cycle(1'b1, 3'b010, pk('0, 22'h0ABCDE, '0), 1'b0, 1'b0);
        idle(4);

        // all three sources at once from rr_ptr = 0
        do_reset();
        cycle(1'b1, 3'b111, pk(22'd1, 22'd2, 22'd3), 1'b0, 1'b0);
        idle(5);

        // overrun while full: first entry kept, three drops
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'b001, pk(22'(i + 16), '0, '0), 1'b0, 1'b1);
        idle(3, 1'b1);
        idle(4);

        // re-capture on source 2 while its entry is granted
        do_reset();
        cycle(1'b1, 3'b100, pk('0, '0, 22'h111111), 1'b0, 1'b0);
        cycle(1'b1, 3'b100, pk('0, '0, 22'h222222), 1'b0, 1'b0);
        idle(4);

        // drop counter saturation, then clear wins over a coincident drop
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'b001, pk(22'(i), '0, '0), 1'b0, 1'b1);
        cycle(1'b1, 3'b001, pk(22'h3FFFFF, '0, '0), 1'b1, 1'b1);
        idle(4);

        // disabled capture
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'b111, pk(22'h1, 22'h2, 22'h3), 1'b0, 1'b0);
        idle(2);

        // asynchronous reset with entries pending and a push in flight
        cycle(1'b1, 3'b111, pk(22'h5, 22'h6, 22'h7), 1'b0, 1'b0);
        idle(1);
        #2 nreset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pending", bus.pending, '0);
        chk("async_rst_push_s", bus.push_s, '0);
        @(negedge clk);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom, $urandom, $urandom};
            cycle($urandom_range(0, 9) != 0, NREQ'($urandom), r[NREQ*DW-1:0],
                  $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);
        end
        idle(10);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
